// File: rtl/mux_rr_n_pkg.sv
// Shared encodings for the round-robin output multiplexer.
// Also holds the wrapping index increment used by the arbiter.
package mux_rr_n_pkg;

   localparam logic       MODO_MANUAL = 1'b0;
   localparam logic       MODO_RR     = 1'b1;

   localparam logic [0:0] VAZIO = 1'b0;
   localparam logic [0:0] CHEIO = 1'b1;

   // Next channel index, wrapping n-1 -> 0 (n need not be a power of 2)
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/mux_rr_n_arbiter.sv
// Combinational round-robin arbiter: first request after i_ptr wins.
// Produces a one-hot grant plus the winning index.
module rr_arbiter_n
   import mux_rr_n_pkg::*;
#(
   parameter int unsigned CANAIS = 4,
   parameter int unsigned SEL_W  = 2
) (
   input  logic [CANAIS-1:0] i_req,
   input  logic [SEL_W-1:0]  i_ptr,
   input  logic              i_en,
   output logic [CANAIS-1:0] o_gnt,
   output logic [SEL_W-1:0]  o_idx
);

   always_comb begin
      logic [SEL_W-1:0] w_cand;
      logic             w_found;
      o_gnt   = '0;
      o_idx   = '0;
      w_cand  = i_ptr;
      w_found = 1'b0;
      for (int k = 0; k < int'(CANAIS); k++) begin
         w_cand = SEL_W'(wrap_inc(32'(w_cand), CANAIS));
         if (i_en && !w_found && i_req[w_cand]) begin
            w_found       = 1'b1;
            o_gnt[w_cand] = 1'b1;
            o_idx         = w_cand;
         end
      end
   end

endmodule

// File: rtl/mux_rr_n.sv
// N-channel valid/ready multiplexer with a one-word registered output buffer.
// Manual (SEL) or round-robin channel selection; refill and drain can overlap.
module mux_rr_n
   import mux_rr_n_pkg::*;
#(
   parameter int unsigned BITS   = 4,
   parameter int unsigned CANAIS = 4,
   parameter int unsigned SEL_W  = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   modo,
   input  logic [SEL_W-1:0]       SEL,
   input  logic [CANAIS*BITS-1:0] D,
   input  logic [CANAIS-1:0]      VALID,
   output logic [CANAIS-1:0]      READY,
   output logic [BITS-1:0]        MUX_OUT,
   output logic [SEL_W-1:0]       MUX_CANAL,
   output logic                   MUX_VALID,
   input  logic                   OUT_READY
);

   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;
   logic [BITS-1:0]   r_out;
   logic [SEL_W-1:0]  r_canal;
   logic [SEL_W-1:0]  r_ptr;

   logic              w_aceita;
   logic              w_en_rr;
   logic              w_en_man;
   logic              w_any;
   logic [CANAIS-1:0] w_rr_gnt;
   logic [CANAIS-1:0] w_man_gnt;
   logic [CANAIS-1:0] w_gnt;
   logic [SEL_W-1:0]  w_rr_idx;
   logic [SEL_W-1:0]  w_man_idx;
   logic [SEL_W-1:0]  w_idx;
   logic [BITS-1:0]   w_data;

   // Grants are suppressed during reset so READY reads 0 while it is held
   assign w_aceita = (r_state == VAZIO) || OUT_READY;
   assign w_en_rr  = w_aceita && !reset && (modo == MODO_RR);
   assign w_en_man = w_aceita && !reset && (modo == MODO_MANUAL);

   rr_arbiter_n #(
      .CANAIS (CANAIS),
      .SEL_W  (SEL_W)
   ) u_arb (
      .i_req (VALID),
      .i_ptr (r_ptr),
      .i_en  (w_en_rr),
      .o_gnt (w_rr_gnt),
      .o_idx (w_rr_idx)
   );

   // Out-of-range SEL matches no channel, so it never grants
   always_comb begin
      w_man_gnt = '0;
      w_man_idx = '0;
      for (int i = 0; i < int'(CANAIS); i++) begin
         if (w_en_man && (SEL == SEL_W'(i)) && VALID[i]) begin
            w_man_gnt[i] = 1'b1;
            w_man_idx    = SEL_W'(i);
         end
      end
   end

   assign w_gnt = w_rr_gnt | w_man_gnt;
   assign w_idx = (modo == MODO_RR) ? w_rr_idx : w_man_idx;
   assign w_any = |w_gnt;

   always_comb begin
      w_data = '0;
      for (int i = 0; i < int'(CANAIS); i++) begin
         if (w_gnt[i]) w_data = D[i*BITS +: BITS];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) r_state <= VAZIO;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         VAZIO:   if (w_any) w_state_nxt = CHEIO;
         CHEIO:   if (OUT_READY && !w_any) w_state_nxt = VAZIO;
         default: w_state_nxt = VAZIO;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_out   <= '1;
         r_canal <= '0;
         r_ptr   <= SEL_W'(CANAIS - 1);
      end else if (w_any) begin
         r_out   <= w_data;
         r_canal <= w_idx;
         r_ptr   <= w_idx;
      end
   end

   assign READY     = w_gnt;
   assign MUX_OUT   = r_out;
   assign MUX_CANAL = r_canal;
   assign MUX_VALID = (r_state == CHEIO);

endmodule

// File: tb/tb_mux_rr_n.sv
// Bench for mux_rr_n: directed scenarios plus randomized traffic checked
// against a transaction-level model of the buffer, pointer and grant rules.
module tb_mux_rr_n;

   localparam int NCH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        modo;
   logic [1:0]  sel;
   logic [15:0] d;
   logic [3:0]  valid;
   logic [3:0]  ready;
   logic [3:0]  mux_out;
   logic [1:0]  canal;
   logic        mvalid;
   logic        out_ready;

   logic        modo3;
   logic [1:0]  sel3;
   logic [11:0] d3;
   logic [2:0]  valid3;
   logic [2:0]  ready3;
   logic [3:0]  mux_out3;
   logic [1:0]  canal3;
   logic        mvalid3;

   int total = 0;
   int bad   = 0;

   bit         m_valid = 1'b0;
   logic [3:0] m_out   = 4'hF;
   int         m_canal = 0;
   int         m_ptr   = NCH - 1;

   always #5 clk = ~clk;

   mux_rr_n #(.BITS(4), .CANAIS(4), .SEL_W(2)) dut (
      .clock(clk), .reset(rst), .modo(modo), .SEL(sel), .D(d), .VALID(valid),
      .READY(ready), .MUX_OUT(mux_out), .MUX_CANAL(canal), .MUX_VALID(mvalid),
      .OUT_READY(out_ready)
   );

   mux_rr_n #(.BITS(4), .CANAIS(3), .SEL_W(2)) dut3 (
      .clock(clk), .reset(rst), .modo(modo3), .SEL(sel3), .D(d3), .VALID(valid3),
      .READY(ready3), .MUX_OUT(mux_out3), .MUX_CANAL(canal3), .MUX_VALID(mvalid3),
      .OUT_READY(out_ready)
   );

   // Which channel the rules award this cycle, or -1 for none
   function automatic int m_grant();
      if (rst) return -1;
      if (m_valid && !out_ready) return -1;
      if (modo == 1'b0) begin
         if (int'(sel) < NCH && valid[sel]) return int'(sel);
         return -1;
      end
      for (int k = 1; k <= NCH; k++)
         if (valid[(m_ptr + k) % NCH]) return (m_ptr + k) % NCH;
      return -1;
   endfunction

   function automatic logic [3:0] exp_ready();
      logic [3:0] r;
      int g;
      r = '0;
      g = m_grant();
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   task automatic tick();
      int g;
      if (rst) begin
         m_valid = 1'b0; m_out = 4'hF; m_canal = 0; m_ptr = NCH - 1;
      end else begin
         g = m_grant();
         if (g >= 0) begin
            m_out = d[g*4 +: 4]; m_canal = g; m_valid = 1'b1; m_ptr = g;
         end else if (out_ready) begin
            m_valid = 1'b0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; modo = 1'b0; sel = 2'd0; valid = 4'b1111; d = 16'h1234; out_ready = 1'b1;
      modo3 = 1'b0; sel3 = 2'd0; valid3 = 3'b111; d3 = 12'h123;
      tick(); tick();
      total++; if (mux_out !== 4'hF) begin bad++; $display("FAIL reset_out: got %h want %h", mux_out, 4'hF); end
      total++; if (mvalid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", mvalid); end
      total++; if (canal !== 2'd0) begin bad++; $display("FAIL reset_canal: got %0d want 0", canal); end
      total++; if (ready !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b want 0000", ready); end
      total++; if (ready3 !== 3'b000) begin bad++; $display("FAIL reset_ready3: got %b want 000", ready3); end
      rst = 1'b0; valid = '0; valid3 = '0;
      #1;
   endtask

   task automatic test_manual();
      modo = 1'b0; sel = 2'd2; d = 16'h0A00; valid = 4'b0100; out_ready = 1'b1;
      #1;
      total++; if (ready !== 4'b0100) begin bad++; $display("FAIL man_ready: got %b want 0100", ready); end
      tick();
      valid = '0;
      #1;
      total++; if (mux_out !== 4'hA) begin bad++; $display("FAIL man_out: got %h want a", mux_out); end
      total++; if (canal !== 2'd2) begin bad++; $display("FAIL man_canal: got %0d want 2", canal); end
      total++; if (mvalid !== 1'b1) begin bad++; $display("FAIL man_valid: got %b want 1", mvalid); end
      tick();
      total++; if (mvalid !== 1'b0) begin bad++; $display("FAIL man_drain: got %b want 0", mvalid); end
   endtask

   task automatic test_round_robin();
      logic [3:0] er;
      rst = 1'b1; tick(); rst = 1'b0;
      modo = 1'b1; valid = 4'b1111; d = 16'h3210; out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         er = 4'b0001 << (c % 4);
         #1;
         total++; if (ready !== er) begin bad++; $display("FAIL rr_ready[%0d]: got %b want %b", c, ready, er); end
         tick();
         total++; if (canal !== 2'(c % 4)) begin bad++; $display("FAIL rr_canal[%0d]: got %0d want %0d", c, canal, c % 4); end
         total++; if (mux_out !== 4'(c % 4)) begin bad++; $display("FAIL rr_out[%0d]: got %h want %0d", c, mux_out, c % 4); end
         total++; if (mvalid !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d]: got %b want 1", c, mvalid); end
      end
      valid = '0;
   endtask

   task automatic test_stall();
      rst = 1'b1; tick(); rst = 1'b0;
      modo = 1'b0; sel = 2'd3; d = 16'h3000; valid = 4'b1000; out_ready = 1'b1;
      tick();
      valid = '0;
      #1;
      total++; if (mux_out !== 4'h3) begin bad++; $display("FAIL stall_load: got %h want 3", mux_out); end
      modo = 1'b1; valid = 4'b0001; out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         total++; if (ready !== 4'b0000) begin bad++; $display("FAIL stall_ready[%0d]: got %b want 0000", c, ready); end
         tick();
         total++; if (mux_out !== 4'h3) begin bad++; $display("FAIL stall_out[%0d]: got %h want 3", c, mux_out); end
         total++; if (mvalid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d]: got %b want 1", c, mvalid); end
      end
      out_ready = 1'b1;
      #1;
      total++; if (ready !== 4'b0001) begin bad++; $display("FAIL stall_release: got %b want 0001", ready); end
      tick();
      valid = '0;
      total++; if (mux_out !== 4'h0) begin bad++; $display("FAIL stall_refill: got %h want 0", mux_out); end
      total++; if (canal !== 2'd0 || mvalid !== 1'b1) begin bad++; $display("FAIL stall_refill_ch: got %0d/%b want 0/1", canal, mvalid); end
   endtask

   task automatic test_sparse();
      rst = 1'b1; tick(); rst = 1'b0;
      modo = 1'b1; d = 16'hC005; valid = 4'b0001; out_ready = 1'b1;
      tick();
      valid = 4'b1001;
      #1;
      total++; if (ready !== 4'b1000) begin bad++; $display("FAIL sparse_ready3: got %b want 1000", ready); end
      tick();
      valid = 4'b0001;
      total++; if (canal !== 2'd3 || mux_out !== 4'hC) begin bad++; $display("FAIL sparse_g3: got %0d/%h want 3/c", canal, mux_out); end
      #1;
      total++; if (ready !== 4'b0001) begin bad++; $display("FAIL sparse_ready0: got %b want 0001", ready); end
      tick();
      valid = '0;
      total++; if (canal !== 2'd0 || mux_out !== 4'h5) begin bad++; $display("FAIL sparse_g0: got %0d/%h want 0/5", canal, mux_out); end
      tick();
      modo3 = 1'b0; sel3 = 2'd3; d3 = 12'h987; valid3 = 3'b111;
      #1;
      total++; if (ready3 !== 3'b000) begin bad++; $display("FAIL oor_ready: got %b want 000", ready3); end
      tick();
      total++; if (mvalid3 !== 1'b0) begin bad++; $display("FAIL oor_valid: got %b want 0", mvalid3); end
      sel3 = 2'd2;
      #1;
      total++; if (ready3 !== 3'b100) begin bad++; $display("FAIL n3_ready: got %b want 100", ready3); end
      tick();
      valid3 = '0;
      total++; if (mux_out3 !== 4'h9 || canal3 !== 2'd2 || mvalid3 !== 1'b1) begin
         bad++; $display("FAIL n3_out: got %h/%0d/%b want 9/2/1", mux_out3, canal3, mvalid3);
      end
   endtask

   task automatic test_reset_mid();
      modo = 1'b1; valid = 4'b1111; d = 16'h7654; out_ready = 1'b1;
      tick(); tick();
      total++; if (mvalid !== 1'b1) begin bad++; $display("FAIL mid_pre: got %b want 1", mvalid); end
      rst = 1'b1;
      tick();
      total++; if (mvalid !== 1'b0 || mux_out !== 4'hF || canal !== 2'd0) begin
         bad++; $display("FAIL mid_reset: got %b/%h/%0d want 0/f/0", mvalid, mux_out, canal);
      end
      total++; if (ready !== 4'b0000) begin bad++; $display("FAIL mid_ready: got %b want 0000", ready); end
      rst = 1'b0;
      #1;
      total++; if (ready !== 4'b0001) begin bad++; $display("FAIL mid_first: got %b want 0001", ready); end
      tick();
      valid = '0;
      total++; if (canal !== 2'd0 || mux_out !== 4'h4) begin bad++; $display("FAIL mid_grant: got %0d/%h want 0/4", canal, mux_out); end
      tick();
   endtask

   task automatic test_random();
      logic [3:0] er;
      int g;
      for (int it = 0; it < 400; it++) begin
         if ($urandom_range(0, 15) == 0) modo = ~modo;
         sel       = 2'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         rst       = ($urandom_range(0, 60) == 0);
         for (int i = 0; i < NCH; i++) begin
            if (!valid[i] && $urandom_range(0, 1) == 1) begin
               valid[i]     = 1'b1;
               d[i*4 +: 4]  = 4'($urandom);
            end
         end
         #1;
         er = exp_ready();
         total++; if (ready !== er) begin bad++; $display("FAIL rand_ready[%0d]: got %b want %b", it, ready, er); end
         g = m_grant();
         tick();
         total++; if (mux_out !== m_out || canal !== 2'(m_canal) || mvalid !== m_valid) begin
            bad++; $display("FAIL rand_out[%0d]: got %h/%0d/%b want %h/%0d/%b",
                            it, mux_out, canal, mvalid, m_out, m_canal, m_valid);
         end
         if (g >= 0) valid[g] = 1'b0;
      end
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; modo = 1'b0; sel = '0; d = '0; valid = '0; out_ready = 1'b1;
      modo3 = 1'b0; sel3 = '0; d3 = '0; valid3 = '0;
      test_reset();
      test_manual();
      test_round_robin();
      test_stall();
      test_sparse();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
